rename_rat: RTL and testbench

Parametrised register alias table for the dispatch stage, generalising the single-instruction ARF/ROB table plus tag table into one block that renames `DISPATCH_WIDTH` instructions per cycle. It resolves intra-group dependencies and tracks per-register producer readiness from wakeup broadcasts, so dispatch no longer needs to query the ROB for source readiness. It clears mappings on retire and clears all speculative state on redirect flush. The block sits between decode and the IIQ/LSQ payload assembly in dispatch.

---
 rtl/rename_rat.sv | 147 ++++++++++++++
 tb/tb_rename_rat.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rat.sv
// Register alias table for dispatch: renames DISPATCH_WIDTH instructions per cycle,
// forwards intra-group producers, and tracks producer readiness from wakeup broadcasts.
module rename_rat #(
  parameter int N_ARCH_REGS    = 32,
  parameter int ARF_ID_WIDTH   = 5,
  parameter int ROB_ID_WIDTH   = 4,
  parameter int DISPATCH_WIDTH = 2,
  parameter int N_WAKEUP       = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_aL,
  input  logic [DISPATCH_WIDTH-1:0]              rename_valid,
  input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] rs1,
  input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] rs2,
  input  logic [DISPATCH_WIDTH-1:0]              rd_valid,
  input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] rd,
  input  logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] rd_rob_id,
  output logic [DISPATCH_WIDTH-1:0]              src1_spec,
  output logic [DISPATCH_WIDTH-1:0]              src2_spec,
  output logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] src1_rob_id,
  output logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] src2_rob_id,
  output logic [DISPATCH_WIDTH-1:0]              src1_ready,
  output logic [DISPATCH_WIDTH-1:0]              src2_ready,
  input  logic                                   retire_valid,
  input  logic [ARF_ID_WIDTH-1:0]                retire_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]                retire_rob_id,
  input  logic [N_WAKEUP-1:0]                    wakeup_valid,
  input  logic [N_WAKEUP*ROB_ID_WIDTH-1:0]       wakeup_rob_id,
  input  logic                                   flush,
  output logic [ARF_ID_WIDTH:0]                  spec_count
);

  localparam int AW    = ARF_ID_WIDTH;
  localparam int RW    = ROB_ID_WIDTH;
  localparam int DW    = DISPATCH_WIDTH;
  localparam int CNT_W = ARF_ID_WIDTH + 1;

  typedef struct packed {
    logic          spec;
    logic [RW-1:0] rob_id;
    logic          ready;
  } lookup_t;

  logic [N_ARCH_REGS-1:0] spec_q, spec_d;
  logic [N_ARCH_REGS-1:0] ready_q, ready_d;
  logic [RW-1:0]          rob_q [N_ARCH_REGS];
  logic [RW-1:0]          rob_d [N_ARCH_REGS];
  logic [CNT_W-1:0]       spec_count_d;

  function automatic logic wake_hit(input logic [RW-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_WAKEUP; k++) begin
      if (wakeup_valid[k] && wakeup_rob_id[k*RW +: RW] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Older slots are scanned oldest-first so the youngest older producer overwrites the rest.
  function automatic lookup_t lookup(input logic [AW-1:0] src, input int slot);
    lookup_t r;
    logic    fwd;
    r   = '{spec: 1'b0, rob_id: '0, ready: 1'b1};
    fwd = 1'b0;
    if (src != '0) begin
      for (int j = 0; j < DW; j++) begin
        if (j < slot && rename_valid[j] && rd_valid[j] && rd[j*AW +: AW] == src) begin
          r.spec   = 1'b1;
          r.rob_id = rd_rob_id[j*RW +: RW];
          r.ready  = 1'b0;
          fwd      = 1'b1;
        end
      end
      if (!fwd) begin
        r.spec   = spec_q[src];
        r.rob_id = rob_q[src];
        r.ready  = !spec_q[src] || ready_q[src] || wake_hit(rob_q[src]);
      end
    end
    return r;
  endfunction

  always_comb begin
    lookup_t l1, l2;
    src1_spec   = '0;
    src2_spec   = '0;
    src1_rob_id = '0;
    src2_rob_id = '0;
    src1_ready  = '0;
    src2_ready  = '0;
    for (int i = 0; i < DW; i++) begin
      l1 = lookup(rs1[i*AW +: AW], i);
      l2 = lookup(rs2[i*AW +: AW], i);
      src1_spec[i]            = l1.spec;
      src1_rob_id[i*RW +: RW] = l1.rob_id;
      src1_ready[i]           = l1.ready;
      src2_spec[i]            = l2.spec;
      src2_rob_id[i*RW +: RW] = l2.rob_id;
      src2_ready[i]           = l2.ready;
    end
  end

  // Updates are applied lowest priority first so later writes override: wakeup, retire, rename, flush.
  always_comb begin
    spec_d  = spec_q;
    ready_d = ready_q;
    rob_d   = rob_q;
    for (int r = 1; r < N_ARCH_REGS; r++) begin
      if (spec_q[r] && wake_hit(rob_q[r])) ready_d[r] = 1'b1;
    end
    if (retire_valid && spec_q[retire_arf_id] && rob_q[retire_arf_id] == retire_rob_id) begin
      spec_d[retire_arf_id] = 1'b0;
    end
    for (int i = 0; i < DW; i++) begin
      if (rename_valid[i] && rd_valid[i] && rd[i*AW +: AW] != '0) begin
        spec_d[rd[i*AW +: AW]]  = 1'b1;
        ready_d[rd[i*AW +: AW]] = 1'b0;
        rob_d[rd[i*AW +: AW]]   = rd_rob_id[i*RW +: RW];
      end
    end
    if (flush) begin
      spec_d  = '0;
      ready_d = '0;
    end
    spec_count_d = '0;
    for (int r = 0; r < N_ARCH_REGS; r++) begin
      spec_count_d = spec_count_d + CNT_W'(spec_d[r]);
    end
  end

  // NOTE: the tag array is reset too (it is only 32 entries of flops, not a RAM), so
  // lookups never expose X after reset and all three fields start at 0.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      spec_q     <= '0;
      ready_q    <= '0;
      rob_q      <= '{default: '0};
      spec_count <= '0;
    end else begin
      spec_q     <= spec_d;
      ready_q    <= ready_d;
      rob_q      <= rob_d;
      spec_count <= spec_count_d;
    end
  end

endmodule

// File: tb/tb_rename_rat.sv
// Self-checking bench for rename_rat: expectations are queued as stimulus is driven
// and popped against the DUT outputs once they have settled.
module tb_rename_rat;

  localparam int AW = 5;
  localparam int RW = 4;
  localparam int DW = 2;
  localparam int NW = 2;

  logic              clk;
  logic              rst_aL;
  logic [DW-1:0]     rename_valid;
  logic [DW*AW-1:0]  rs1, rs2, rd;
  logic [DW-1:0]     rd_valid;
  logic [DW*RW-1:0]  rd_rob_id;
  logic [DW-1:0]     src1_spec, src2_spec, src1_ready, src2_ready;
  logic [DW*RW-1:0]  src1_rob_id, src2_rob_id;
  logic              retire_valid;
  logic [AW-1:0]     retire_arf_id;
  logic [RW-1:0]     retire_rob_id;
  logic [NW-1:0]     wakeup_valid;
  logic [NW*RW-1:0]  wakeup_rob_id;
  logic              flush;
  logic [AW:0]       spec_count;

  rename_rat #(
    .N_ARCH_REGS(32), .ARF_ID_WIDTH(AW), .ROB_ID_WIDTH(RW),
    .DISPATCH_WIDTH(DW), .N_WAKEUP(NW)
  ) dut (
    .clk(clk), .rst_aL(rst_aL),
    .rename_valid(rename_valid), .rs1(rs1), .rs2(rs2),
    .rd_valid(rd_valid), .rd(rd), .rd_rob_id(rd_rob_id),
    .src1_spec(src1_spec), .src2_spec(src2_spec),
    .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .retire_valid(retire_valid), .retire_arf_id(retire_arf_id), .retire_rob_id(retire_rob_id),
    .wakeup_valid(wakeup_valid), .wakeup_rob_id(wakeup_rob_id),
    .flush(flush), .spec_count(spec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_SPEC, K_ROB, K_RDY, K_CNT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          slot;
    int          src;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observe(input exp_t e);
    case (e.kind)
      K_SPEC:  return (e.src == 1) ? 32'(src1_spec[e.slot]) : 32'(src2_spec[e.slot]);
      K_ROB:   return (e.src == 1) ? 32'(src1_rob_id[e.slot*RW +: RW]) : 32'(src2_rob_id[e.slot*RW +: RW]);
      K_RDY:   return (e.src == 1) ? 32'(src1_ready[e.slot]) : 32'(src2_ready[e.slot]);
      default: return 32'(spec_count);
    endcase
  endfunction

  task automatic push(input string name, input kind_e k, input int slot, input int src, input int val);
    exp_t e;
    e.name = name; e.kind = k; e.slot = slot; e.src = src; e.val = 32'(val);
    sb.push_back(e);
  endtask

  // rob_id is only meaningful when the source is speculative.
  task automatic exp_src(input string name, input int slot, input int src,
                         input int spec, input int rob, input int rdy);
    push($sformatf("%s.s%0d.src%0d.spec", name, slot, src), K_SPEC, slot, src, spec);
    if (spec != 0) push($sformatf("%s.s%0d.src%0d.rob", name, slot, src), K_ROB, slot, src, rob);
    push($sformatf("%s.s%0d.src%0d.rdy", name, slot, src), K_RDY, slot, src, rdy);
  endtask

  task automatic exp_cnt(input string name, input int val);
    push({name, ".spec_count"}, K_CNT, 0, 0, val);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, observe(e), e.val);
    end
  endtask

  task automatic idle();
    rename_valid  = '0;
    rs1           = '0;
    rs2           = '0;
    rd_valid      = '0;
    rd            = '0;
    rd_rob_id     = '0;
    retire_valid  = 1'b0;
    retire_arf_id = '0;
    retire_rob_id = '0;
    wakeup_valid  = '0;
    wakeup_rob_id = '0;
    flush         = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic set_slot(input int s, input logic rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic dv, input logic [AW-1:0] d, input logic [RW-1:0] t);
    rename_valid[s]      = rv;
    rs1[s*AW +: AW]      = a1;
    rs2[s*AW +: AW]      = a2;
    rd_valid[s]          = dv;
    rd[s*AW +: AW]       = d;
    rd_rob_id[s*RW +: RW] = t;
  endtask

  task automatic retire(input logic [AW-1:0] a, input logic [RW-1:0] t);
    retire_valid  = 1'b1;
    retire_arf_id = a;
    retire_rob_id = t;
  endtask

  task automatic wake(input int ch, input logic [RW-1:0] t);
    wakeup_valid[ch]           = 1'b1;
    wakeup_rob_id[ch*RW +: RW] = t;
  endtask

  initial begin
    rst_aL = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    exp_cnt("reset_hold", 0);
    drain();
    rst_aL = 1'b1;

    for (int r = 1; r < 32; r++) begin
      cyc();
      set_slot(0, 1'b0, AW'(r), 5'd0, 1'b0, 5'd0, 4'd0);
      set_slot(1, 1'b0, 5'd0, AW'(r), 1'b0, 5'd0, 4'd0);
      exp_src($sformatf("reset_x%0d", r), 0, 1, 0, 0, 1);
      exp_src($sformatf("reset_x%0d", r), 1, 2, 0, 0, 1);
      if (r == 31) exp_cnt("reset", 0);
      drain();
    end

    // rename x5 -> tag 3, then wakeup with a wrong tag, the right tag, and persistence
    cyc(); set_slot(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 4'd3); drain();
    cyc();
    set_slot(0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0);
    set_slot(1, 1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 4'd0);
    wake(0, 4'd4);
    exp_src("x5_nowake", 0, 1, 1, 3, 0);
    exp_src("x5_nowake", 1, 2, 1, 3, 0);
    exp_cnt("x5_nowake", 1);
    drain();
    cyc();
    set_slot(0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0);
    wake(1, 4'd3);
    exp_src("x5_wake_same", 0, 1, 1, 3, 1);
    drain();
    cyc();
    set_slot(0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("x5_wake_held", 0, 1, 1, 3, 1);
    exp_cnt("x5_wake_held", 1);
    drain();

    // intra-group forwarding: own slot never forwards, younger slot does
    cyc();
    set_slot(0, 1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 4'd2);
    set_slot(1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 4'd0);
    exp_src("intra_own", 0, 1, 0, 0, 1);
    exp_src("intra_fwd", 1, 1, 1, 2, 0);
    exp_src("intra_fwd", 1, 2, 1, 2, 0);
    drain();
    cyc();
    set_slot(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 4'd4);
    set_slot(1, 1'b1, 5'd7, 5'd0, 1'b1, 5'd9, 4'd5);
    exp_src("x7_table", 1, 1, 1, 2, 0);
    exp_cnt("x7_table", 2);
    drain();
    // slot0 has rd_valid but no rename_valid, so slot1 must read the table
    cyc();
    set_slot(0, 1'b0, 5'd9, 5'd0, 1'b1, 5'd5, 4'd7);
    set_slot(1, 1'b0, 5'd5, 5'd9, 1'b0, 5'd0, 4'd0);
    exp_src("x9_youngest", 0, 1, 1, 5, 0);
    exp_src("x9_youngest", 1, 2, 1, 5, 0);
    exp_src("no_fwd_invalid", 1, 1, 1, 3, 1);
    exp_cnt("x9_youngest", 3);
    drain();
    cyc();
    set_slot(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 4'd7);
    set_slot(1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("fwd_over_table", 1, 1, 1, 7, 0);
    drain();

    // stale retire
    cyc();
    set_slot(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 4'd1);
    set_slot(1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("x5_renamed", 1, 1, 1, 7, 0);
    exp_cnt("x5_renamed", 3);
    drain();
    cyc(); set_slot(1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 4'd6); drain();
    cyc();
    retire(5'd4, 4'd1);
    set_slot(0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("x4_tag6", 0, 1, 1, 6, 0);
    exp_cnt("x4_tag6", 4);
    drain();
    cyc();
    retire(5'd4, 4'd6);
    set_slot(0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("stale_retire", 0, 1, 1, 6, 0);
    exp_cnt("stale_retire", 4);
    drain();
    cyc();
    set_slot(0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd8, 4'd2);
    exp_src("retired_x4", 0, 1, 0, 0, 1);
    exp_cnt("retired_x4", 3);
    drain();

    // retire and rename on the same register
    cyc();
    retire(5'd8, 4'd2);
    set_slot(1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 4'd9);
    set_slot(0, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("x8_tag2", 0, 1, 1, 2, 0);
    exp_cnt("x8_tag2", 4);
    drain();
    // rename+wakeup same tag, x0 write, zero-source forwarding, wakeup of x7
    cyc();
    set_slot(0, 1'b1, 5'd8, 5'd0, 1'b1, 5'd11, 4'd12);
    set_slot(1, 1'b1, 5'd0, 5'd7, 1'b1, 5'd0, 4'd13);
    wake(0, 4'd12);
    wake(1, 4'd2);
    exp_src("retire_vs_rename", 0, 1, 1, 9, 0);
    exp_src("x0_src", 1, 1, 0, 0, 1);
    exp_src("x7_wake_same", 1, 2, 1, 2, 1);
    exp_cnt("retire_vs_rename", 4);
    drain();
    cyc();
    set_slot(0, 1'b0, 5'd11, 5'd7, 1'b0, 5'd0, 4'd0);
    set_slot(1, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("rename_over_wake", 0, 1, 1, 12, 0);
    exp_src("x7_wake_held", 0, 2, 1, 2, 1);
    exp_src("x8_tag9", 1, 1, 1, 9, 0);
    exp_cnt("x0_not_counted", 5);
    drain();

    // flush together with a rename
    cyc();
    flush = 1'b1;
    set_slot(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd10, 4'd10);
    set_slot(1, 1'b0, 5'd11, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("pre_flush", 1, 1, 1, 12, 0);
    drain();
    cyc();
    set_slot(0, 1'b1, 5'd10, 5'd5, 1'b1, 5'd12, 4'd14);
    set_slot(1, 1'b0, 5'd11, 5'd7, 1'b0, 5'd0, 4'd0);
    exp_src("flush_x10", 0, 1, 0, 0, 1);
    exp_src("flush_x5", 0, 2, 0, 0, 1);
    exp_src("flush_x11", 1, 1, 0, 0, 1);
    exp_src("flush_x7", 1, 2, 0, 0, 1);
    exp_cnt("flush", 0);
    drain();
    cyc();
    set_slot(0, 1'b0, 5'd12, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("post_flush_x12", 0, 1, 1, 14, 0);
    exp_cnt("post_flush", 1);
    drain();

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst_aL = 1'b0;
    exp_src("async_rst_x12", 0, 1, 0, 0, 1);
    exp_cnt("async_rst", 0);
    drain();
    @(negedge clk);
    rst_aL = 1'b1;
    idle();
    set_slot(0, 1'b1, 5'd12, 5'd0, 1'b1, 5'd13, 4'd15);
    exp_src("after_rst_x12", 0, 1, 0, 0, 1);
    drain();
    cyc();
    set_slot(0, 1'b0, 5'd13, 5'd0, 1'b0, 5'd0, 4'd0);
    exp_src("first_rename", 0, 1, 1, 15, 0);
    exp_cnt("first_rename", 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
